event_tracking: RTL and testbench
=================================

Name: event_tracking

Overview:
Front-end stage of the clock monitor, directly upstream of event_filtering. It synchronises the monitored clock into the system domain and detects its edges as single-cycle events. It runs the rate counter that measures cycles since the last accepted event. It also captures the most recent high and low half-period widths, using the filter's accept decision fed back combinationally. The block supplies event_filtering with primary_clk_i, event_i and current_rate_counter_i, and takes ignore_filtered_event_o back as accept_event_i.

Parameters:
RATE_COUNTER_WIDTH, clks_alot_p::RATE_COUNTER_WIDTH (16), width of the rate counter and of the captured rates
SYNC_STAGES, 2, flops in the input synchroniser; legal values are 2 or more

Ports:
clk_i  input  1  system clock
sync_rst_i  input  1  synchronous, active-high reset
enable_i  input  1  tracking enable
raw_clk_i  input  1  monitored clock, asynchronous to clk_i
accept_event_i  input  1  accept decision for the current event_o; driven by event_filtering ignore_filtered_event_o
primary_clk_o  input  1  synchronised level of raw_clk_i
event_o  output  1  one-cycle pulse on each synchronised edge
rising_event_o  output  1  event_o qualified by a rising edge
falling_event_o  output  1  event_o qualified by a falling edge
current_rate_counter_o  output  RATE_COUNTER_WIDTH  cycles since the last accepted event, minus one
last_high_rate_o  output  RATE_COUNTER_WIDTH  last captured high half-period, minus one
last_low_rate_o  output  RATE_COUNTER_WIDTH  last captured low half-period, minus one
high_rate_valid_o  output  1  last_high_rate_o holds a real measurement
low_rate_valid_o  output  1  last_low_rate_o holds a real measurement
stalled_o  output  1  counter saturated with no accepted event

Note: primary_clk_o is an output; its direction above is a typo and it is driven by this block.

Behaviour:
- Reset (sync_rst_i high at a clk_i edge): all registers and outputs go to 0, including the synchroniser chain; state becomes IDLE.
- Synchroniser:
  - raw_clk_i passes through SYNC_STAGES flops; the last stage is primary_clk_o.
  - prev_level is primary_clk_o delayed by one flop.
  - event_o = enable_i && (primary_clk_o != prev_level), computed combinationally.
  - A raw edge sampled at clk edge k gives event_o high during the cycle after edge k+SYNC_STAGES-1, for exactly one cycle.
- Edge qualifiers: rising_event_o = event_o && primary_clk_o; falling_event_o = event_o && ~primary_clk_o.
- Accepted event: accepted = event_o && accept_event_i. accept_event_i is ignored when event_o is low.
- Counter:
  - On an accepted event, it loads 0 at the next edge.
  - Otherwise it increments by 1, saturating at all-ones.
  - It holds 0 in IDLE.
  - An event that is not accepted does not reset the counter; this is the glitch-debounce behaviour.
- State machine:
  - IDLE to ARMING when enable_i is high. The counter and captures are held, and both valid flags are cleared.
  - ARMING to TRACKING on the first accepted event. Nothing is captured, because the elapsed interval is partial; the counter restarts.
  - TRACKING, on each accepted event: the current counter value is captured. An accepted falling edge (the level was high) writes last_high_rate_o and sets high_rate_valid_o. An accepted rising edge writes last_low_rate_o and sets low_rate_valid_o. The capture is visible at the next edge.
  - TRACKING to ARMING when the counter reaches all-ones with no accepted event that cycle. stalled_o sets, both valid flags clear, and the captured rate values are kept.
  - stalled_o clears on the next accepted event.
  - Any state to IDLE when enable_i is low; this takes priority over everything except reset. In IDLE, stalled_o clears.
- Simultaneous conditions:
  - An accepted event in the same cycle the counter is at all-ones counts as an accepted event: it captures all-ones, and no stall occurs.
  - enable_i falling in the same cycle as an accepted event goes to IDLE, and no capture happens.
- Reset mid-operation: everything returns to reset values on the next edge. The first post-reset edge is treated as an ARMING event only; it is never captured.
- Widths: the counter, captured rates and comparisons are all unsigned RATE_COUNTER_WIDTH bits; no overflow wrap is permitted.

Test Plan:
1. Steady 50% duty: W=16, SYNC_STAGES=2, accept_event_i tied high, raw_clk_i toggling every 10 clk_i cycles. After the second accepted edge, last_high_rate_o = 9 and last_low_rate_o = 9, both valids are high, and current_rate_counter_o = 9 at each event.
2. Asymmetric duty, high for 6 cycles and low for 14 -> last_high_rate_o = 5, last_low_rate_o = 13; rising_event_o and falling_event_o alternate with a single pulse each.
3. Rejected glitch: accept_event_i held low for one event mid-high-phase, with the period otherwise 10/10 -> the counter is not reset; the next accepted falling edge captures the cumulative count (for example 9); the valids stay set.
4. Saturation: W=8, raw_clk_i frozen for 300 cycles in TRACKING -> the counter holds at 255, stalled_o rises, and the state returns to ARMING with the valids cleared. The next accepted edge clears stalled_o and captures nothing. The one after that captures.
5. Enable and latency: with enable_i low, raw edges give event_o = 0 and counter = 0. After enable_i rises, the first raw edge produces event_o exactly SYNC_STAGES cycles after sampling, 1 cycle wide; there is no capture on that first event.
6. Reset mid-operation: sync_rst_i pulsed for one cycle while tracking -> all outputs are 0 the next cycle. The first post-reset edge only arms; captures resume from the second edge.

Source files
------------

// File: rtl/event_tracking.sv
// ============================================================================
// Module   : event_tracking
// Brief    : Synchronises the monitored clock, emits edge events, runs the
//            rate counter and captures the latest high/low half-period widths.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_tracking #(
    parameter int unsigned RATE_COUNTER_WIDTH = 16,
    parameter int unsigned SYNC_STAGES        = 2
) (
    input  logic                          clk_i,
    input  logic                          sync_rst_i,
    input  logic                          enable_i,
    input  logic                          raw_clk_i,
    input  logic                          accept_event_i,
    output logic                          primary_clk_o,
    output logic                          event_o,
    output logic                          rising_event_o,
    output logic                          falling_event_o,
    output logic [RATE_COUNTER_WIDTH-1:0] current_rate_counter_o,
    output logic [RATE_COUNTER_WIDTH-1:0] last_high_rate_o,
    output logic [RATE_COUNTER_WIDTH-1:0] last_low_rate_o,
    output logic                          high_rate_valid_o,
    output logic                          low_rate_valid_o,
    output logic                          stalled_o
);

    localparam logic [RATE_COUNTER_WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [RATE_COUNTER_WIDTH-1:0] C_CNT_ONE = {{(RATE_COUNTER_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMING   = 2'd1,
        S_TRACKING = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0]        sync_q;
    logic                          prev_q;
    state_e                        state_q, state_d;
    logic [RATE_COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [RATE_COUNTER_WIDTH-1:0] high_q, high_d;
    logic [RATE_COUNTER_WIDTH-1:0] low_q, low_d;
    logic                          hv_q, hv_d;
    logic                          lv_q, lv_d;
    logic                          stalled_q, stalled_d;

    logic                          primary_w;
    logic                          event_w;
    logic                          accepted_w;
    logic                          falling_w;
    logic [RATE_COUNTER_WIDTH-1:0] cnt_inc_w;

    assign primary_w  = sync_q[SYNC_STAGES-1];
    assign event_w    = enable_i && (primary_w != prev_q);
    assign accepted_w = event_w && accept_event_i;
    // Level has already dropped when a falling edge is reported.
    assign falling_w  = event_w && !primary_w;
    assign cnt_inc_w  = (cnt_q == C_CNT_MAX) ? cnt_q : (cnt_q + C_CNT_ONE);

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            high_q    <= '0;
            low_q     <= '0;
            hv_q      <= 1'b0;
            lv_q      <= 1'b0;
            stalled_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_clk_i};
            prev_q    <= primary_w;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            high_q    <= high_d;
            low_q     <= low_d;
            hv_q      <= hv_d;
            lv_q      <= lv_d;
            stalled_q <= stalled_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        high_d    = high_q;
        low_d     = low_q;
        hv_d      = hv_q;
        lv_d      = lv_q;
        stalled_d = stalled_q;

        if (!enable_i) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            stalled_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_ARMING;
                    hv_d    = 1'b0;
                    lv_d    = 1'b0;
                end
                S_ARMING: begin
                    // The interval before the first accepted edge is partial, so it is never captured.
                    if (accepted_w) begin
                        state_d   = S_TRACKING;
                        cnt_d     = '0;
                        stalled_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc_w;
                    end
                end
                S_TRACKING: begin
                    if (accepted_w) begin
                        cnt_d     = '0;
                        stalled_d = 1'b0;
                        if (falling_w) begin
                            high_d = cnt_q;
                            hv_d   = 1'b1;
                        end else begin
                            low_d = cnt_q;
                            lv_d  = 1'b1;
                        end
                    end else if (cnt_q == C_CNT_MAX) begin
                        state_d   = S_ARMING;
                        stalled_d = 1'b1;
                        hv_d      = 1'b0;
                        lv_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_inc_w;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign primary_clk_o          = primary_w;
    assign event_o                = event_w;
    assign rising_event_o         = event_w && primary_w;
    assign falling_event_o        = falling_w;
    assign current_rate_counter_o = cnt_q;
    assign last_high_rate_o       = high_q;
    assign last_low_rate_o        = low_q;
    assign high_rate_valid_o      = hv_q;
    assign low_rate_valid_o       = lv_q;
    assign stalled_o              = stalled_q;

endmodule

`default_nettype wire

// File: tb/tb_event_tracking.sv
// ============================================================================
// Module   : tb_event_tracking
// Brief    : Self-checking bench for event_tracking against a cycle-level
//            reference model built from interval counts since the last edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_event_tracking;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int MAX = (1 << W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_ARM   = 1;
    localparam int M_TRACK = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         raw;
    logic         acc;
    logic         primary, ev, rise, fall;
    logic [W-1:0] cnt, high, low;
    logic         hv, lv, stalled;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit raw_hist[$];
    bit m_prev;
    int m_mode;
    int m_since;
    int m_high, m_low;
    bit m_hv, m_lv, m_st;
    bit raw_lvl;
    bit en_lvl;

    always #5 clk = ~clk;

    event_tracking #(
        .RATE_COUNTER_WIDTH (W),
        .SYNC_STAGES        (S)
    ) dut (
        .clk_i                  (clk),
        .sync_rst_i             (rst),
        .enable_i               (en),
        .raw_clk_i              (raw),
        .accept_event_i         (acc),
        .primary_clk_o          (primary),
        .event_o                (ev),
        .rising_event_o         (rise),
        .falling_event_o        (fall),
        .current_rate_counter_o (cnt),
        .last_high_rate_o       (high),
        .last_low_rate_o        (low),
        .high_rate_valid_o      (hv),
        .low_rate_valid_o       (lv),
        .stalled_o              (stalled)
    );

    function automatic int cap(input int v);
        return (v > MAX) ? MAX : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        raw_hist.delete();
        for (int i = 0; i < S; i++) raw_hist.push_back(1'b0);
        m_prev  = 1'b0;
        m_mode  = M_IDLE;
        m_since = 0;
        m_high  = 0;
        m_low   = 0;
        m_hv    = 1'b0;
        m_lv    = 1'b0;
        m_st    = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare all outputs, then advance the model past the edge.
    task automatic cyc(input bit r, input bit e, input bit a, input bit rs);
        bit lvl, m_ev, m_acc, m_fall;
        @(negedge clk);
        raw = r;
        en  = e;
        acc = a;
        rst = rs;
        #1;
        lvl    = raw_hist[0];
        m_ev   = e && (lvl != m_prev);
        m_acc  = m_ev && a;
        m_fall = m_ev && !lvl;
        chk("primary", {31'd0, primary}, {31'd0, lvl});
        chk("event", {31'd0, ev}, {31'd0, m_ev});
        chk("rising", {31'd0, rise}, {31'd0, m_ev && lvl});
        chk("falling", {31'd0, fall}, {31'd0, m_fall});
        chk("counter", {24'd0, cnt}, cap(m_since));
        chk("high_rate", {24'd0, high}, m_high);
        chk("low_rate", {24'd0, low}, m_low);
        chk("high_valid", {31'd0, hv}, {31'd0, m_hv});
        chk("low_valid", {31'd0, lv}, {31'd0, m_lv});
        chk("stalled", {31'd0, stalled}, {31'd0, m_st});

        if (rs) begin
            model_reset();
        end else begin
            if (!e) begin
                m_mode  = M_IDLE;
                m_since = 0;
                m_st    = 1'b0;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_ARM;
                m_hv   = 1'b0;
                m_lv   = 1'b0;
            end else if (m_mode == M_ARM) begin
                if (m_acc) begin
                    m_mode  = M_TRACK;
                    m_since = 0;
                    m_st    = 1'b0;
                end else begin
                    m_since++;
                end
            end else begin
                if (m_acc) begin
                    if (m_fall) begin
                        m_high = cap(m_since);
                        m_hv   = 1'b1;
                    end else begin
                        m_low = cap(m_since);
                        m_lv  = 1'b1;
                    end
                    m_since = 0;
                    m_st    = 1'b0;
                end else if (cap(m_since) == MAX) begin
                    m_mode = M_ARM;
                    m_st   = 1'b1;
                    m_hv   = 1'b0;
                    m_lv   = 1'b0;
                    m_since++;
                end else begin
                    m_since++;
                end
            end
            m_prev = lvl;
            raw_hist.push_back(r);
            if (raw_hist.size() > S) void'(raw_hist.pop_front());
        end
    endtask

    task automatic wave(input int hi, input int lo, input int periods, input bit rand_acc);
        for (int p = 0; p < periods; p++) begin
            for (int i = 0; i < hi; i++)
                cyc(1'b1, 1'b1, rand_acc ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
            for (int i = 0; i < lo; i++)
                cyc(1'b0, 1'b1, rand_acc ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        raw = 1'b0;
        acc = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();

        // Disabled: edges must produce nothing and the counter stays at zero
        for (int i = 0; i < 40; i++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Steady 50% duty
        wave(10, 10, 6, 1'b0);
        chk("steady_high", {24'd0, high}, 32'd9);
        chk("steady_low", {24'd0, low}, 32'd9);
        chk("steady_hv", {31'd0, hv}, 32'd1);
        chk("steady_lv", {31'd0, lv}, 32'd1);

        // Asymmetric duty
        wave(6, 14, 4, 1'b0);
        chk("asym_high", {24'd0, high}, 32'd5);
        chk("asym_low", {24'd0, low}, 32'd13);

        // Randomly rejected events (debounce)
        wave(10, 10, 8, 1'b1);

        // Accepted event landing exactly on a saturated counter
        wave(10, 10, 2, 1'b0);
        wave(256, 256, 1, 1'b0);
        chk("sat_capture", {24'd0, high}, 32'd255);
        chk("sat_no_stall", {31'd0, stalled}, 32'd0);

        // Frozen raw clock: counter saturates and the tracker stalls
        wave(10, 10, 2, 1'b0);
        for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("stall_cnt", {24'd0, cnt}, 32'd255);
        chk("stall_flag", {31'd0, stalled}, 32'd1);
        chk("stall_hv", {31'd0, hv}, 32'd0);
        wave(10, 10, 3, 1'b0);

        // Reset mid-operation
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        chk("rst_outputs", {primary, ev, rise, fall, hv, lv, stalled}, 32'd0);
        chk("rst_cnt", {cnt, high, low}, 32'd0);
        wave(10, 10, 3, 1'b0);

        // Randomised operation
        raw_lvl = 1'b0;
        en_lvl  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) raw_lvl = ~raw_lvl;
            if (en_lvl && $urandom_range(0, 299) == 0) en_lvl = 1'b0;
            else if (!en_lvl && $urandom_range(0, 9) == 0) en_lvl = 1'b1;
            cyc(raw_lvl, en_lvl, $urandom_range(0, 3) != 0, $urandom_range(0, 999) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
